// File: rtl/gcd_datapath.sv
// gcd_datapath: operand registers, compare status and handshakes for a
// subtract-based GCD engine driven by an external controller.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no computation running; a_sub_b/found ignored, A/B hold
// CMP   | controller samples equal/a_gt_b and issues found or continues
// SUB   | one subtraction (A-B into A or B-A into B), then back to CMP
module gcd_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             n_rst,
  input  logic             a_sub_b,
  input  logic             found,
  output logic             equal,
  output logic             a_gt_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] gcd_out,
  input  logic             out_ready,
  output logic             err_underrun,
  output logic             err_overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    SUB  = 2'd2
  } phase_t;

  phase_t           phase, phase_next;
  logic [WIDTH-1:0] reg_a, reg_b;
  logic [WIDTH-1:0] hold_a, hold_b;
  logic             hold_valid;
  logic             capture_in;
  logic             capture_res;
  logic             any_zero;
  logic [WIDTH-1:0] result;

  // A zero operand forces equal so the controller terminates instead of
  // subtracting zero forever; the result is then the nonzero one (or 0).
  assign any_zero    = (reg_a == '0) || (reg_b == '0);
  assign equal       = any_zero || (reg_a == reg_b);
  assign a_gt_b      = !equal && (reg_a > reg_b);
  assign result      = any_zero ? (reg_a | reg_b) : reg_a;

  assign in_ready    = !hold_valid;
  assign capture_in  = in_valid && !hold_valid;
  // A load in the same cycle overrides found, so no result is taken then.
  assign capture_res = (phase == CMP) && found && !n_rst;

  // Operand holding register: filled by the input handshake, emptied by a load.
  // A pair arriving while empty is kept even if a load happens that cycle
  // (that load sees an empty hold and underruns).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_a     <= '0;
      hold_b     <= '0;
    end else if (capture_in) begin
      hold_valid <= 1'b1;
      hold_a     <= a_in;
      hold_b     <= b_in;
    end else if (n_rst) begin
      hold_valid <= 1'b0;
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase <= IDLE;
    else      phase <= phase_next;
  end

  // Next phase: a load restarts from any phase.
  always_comb begin
    phase_next = phase;
    if (n_rst) begin
      phase_next = CMP;
    end else begin
      case (phase)
        IDLE:    phase_next = IDLE;
        CMP:     phase_next = found ? IDLE : SUB;
        SUB:     phase_next = CMP;
        default: phase_next = IDLE;
      endcase
    end
  end

  // Operand registers: load from hold (zeros if empty) or one subtraction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_a <= '0;
      reg_b <= '0;
    end else if (n_rst) begin
      reg_a <= hold_valid ? hold_a : '0;
      reg_b <= hold_valid ? hold_b : '0;
    end else if (phase == SUB) begin
      if (a_sub_b) reg_a <= reg_a - reg_b;
      else         reg_b <= reg_b - reg_a;
    end
  end

  // One-deep result slot; a result arriving while the slot is full and not
  // being drained is dropped, the held result stays stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      gcd_out   <= '0;
    end else if (capture_res && !(out_valid && !out_ready)) begin
      out_valid <= 1'b1;
      gcd_out   <= result;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_underrun <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      if (n_rst && !hold_valid)                    err_underrun <= 1'b1;
      if (capture_res && out_valid && !out_ready)  err_overrun  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gcd_datapath.sv
// Directed testbench for gcd_datapath; the bench plays the controller role.
module tb_gcd_datapath;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             n_rst = 1'b0;
  logic             a_sub_b = 1'b0;
  logic             found = 1'b0;
  logic             equal;
  logic             a_gt_b;
  logic             out_valid;
  logic [WIDTH-1:0] gcd_out;
  logic             out_ready = 1'b0;
  logic             err_underrun;
  logic             err_overrun;

  int compared   = 0;
  int mismatched = 0;

  gcd_datapath #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a_in         (a_in),
    .b_in         (b_in),
    .n_rst        (n_rst),
    .a_sub_b      (a_sub_b),
    .found        (found),
    .equal        (equal),
    .a_gt_b       (a_gt_b),
    .out_valid    (out_valid),
    .gcd_out      (gcd_out),
    .out_ready    (out_ready),
    .err_underrun (err_underrun),
    .err_overrun  (err_overrun)
  );

  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_gcd_out"},   32'(gcd_out), 0);
    check({tag, "_err_under"}, 32'(err_underrun), 0);
    check({tag, "_err_over"},  32'(err_overrun), 0);
    check({tag, "_equal"},     32'(equal), 1);
    check({tag, "_a_gt_b"},    32'(a_gt_b), 0);
  endtask

  // offer an operand pair and wait (bounded) for it to be taken
  task automatic offer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    for (n = 0; n < 20; n++) begin
      if (in_ready) break;
      step();
    end
    check("offer_timeout", 32'(n < 20), 1);
    step();
    in_valid = 1'b0;
  endtask

  // controller behaviour: load, then CMP/SUB until equal, then found
  task automatic run_ctl(input bit ready_on_found);
    int n;
    n_rst = 1'b1;
    step();
    n_rst = 1'b0;
    for (n = 0; n < 700; n++) begin
      if (equal) begin
        found = 1'b1;
        if (ready_on_found) out_ready = 1'b1;
        step();
        found = 1'b0;
        out_ready = 1'b0;
        break;
      end
      step();
      a_sub_b = a_gt_b;
      step();
      a_sub_b = 1'b0;
    end
    check("ctl_timeout", 32'(n < 700), 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset values, no clock edge yet
    #1;
    check_reset_outputs("rst0");
    #2 rst = 1'b1;
    step();

    // GCD(12,8) step by step
    offer(8'd12, 8'd8);
    check("g12_hold_full", 32'(in_ready), 0);
    n_rst = 1'b1;                       // cycle 0
    step();
    n_rst = 1'b0;                       // cycle 1: CMP
    check("g12_c1_a_gt_b", 32'(a_gt_b), 1);
    check("g12_c1_equal", 32'(equal), 0);
    check("g12_c1_in_ready", 32'(in_ready), 1);
    step();                             // cycle 2: SUB, found must be ignored
    a_sub_b = 1'b1;
    found = 1'b1;
    step();                             // cycle 3: CMP
    found = 1'b0;
    a_sub_b = 1'b0;
    check("g12_c3_reg_a", 32'(dut.reg_a), 4);
    check("g12_c3_a_gt_b", 32'(a_gt_b), 0);
    check("g12_c3_equal", 32'(equal), 0);
    check("g12_c3_no_out", 32'(out_valid), 0);
    step();                             // cycle 4: SUB, B-A
    step();                             // cycle 5: CMP
    check("g12_c5_reg_b", 32'(dut.reg_b), 4);
    check("g12_c5_equal", 32'(equal), 1);
    found = 1'b1;
    step();                             // cycle 6
    found = 1'b0;
    check("g12_c6_out_valid", 32'(out_valid), 1);
    check("g12_c6_gcd", 32'(gcd_out), 4);
    // IDLE: subtract select must not touch A
    a_sub_b = 1'b1;
    step();
    a_sub_b = 1'b0;
    check("idle_hold_a", 32'(dut.reg_a), 4);
    check("g12_held", 32'(gcd_out), 4);
    drain();
    check("g12_drained", 32'(out_valid), 0);

    // zero operand (0,9)
    offer(8'd0, 8'd9);
    n_rst = 1'b1;
    step();
    n_rst = 1'b0;
    check("z09_equal_first_cmp", 32'(equal), 1);
    found = 1'b1;
    step();
    found = 1'b0;
    check("z09_gcd", 32'(gcd_out), 9);
    drain();

    // zero operands (0,0); first fill slot with a different value
    offer(8'd7, 8'd7);
    run_ctl(1'b0);
    check("g77_gcd", 32'(gcd_out), 7);
    drain();
    offer(8'd0, 8'd0);
    run_ctl(1'b0);
    check("z00_out_valid", 32'(out_valid), 1);
    check("z00_gcd", 32'(gcd_out), 0);
    drain();

    // underrun: load with empty hold, after a nonzero result in the slot
    offer(8'd15, 8'd10);
    run_ctl(1'b0);
    check("g1510_gcd", 32'(gcd_out), 5);
    drain();
    check("pre_underrun", 32'(err_underrun), 0);
    run_ctl(1'b0);
    check("underrun_flag", 32'(err_underrun), 1);
    check("underrun_out_valid", 32'(out_valid), 1);
    check("underrun_gcd", 32'(gcd_out), 0);
    drain();

    // overrun with back-pressure
    offer(8'd6, 8'd4);
    run_ctl(1'b0);
    check("ovr_first_gcd", 32'(gcd_out), 2);
    check("ovr_no_err_yet", 32'(err_overrun), 0);
    offer(8'd9, 8'd6);
    run_ctl(1'b0);
    check("ovr_gcd_kept", 32'(gcd_out), 2);
    check("ovr_flag", 32'(err_overrun), 1);
    check("ovr_out_valid", 32'(out_valid), 1);
    check("ovr_phase_idle", 32'(dut.phase), 0);
    drain();

    // same, but consumer accepts on the capture cycle
    rst = 1'b0;
    #1;
    check_reset_outputs("rst1");
    #2 rst = 1'b1;
    step();
    offer(8'd6, 8'd4);
    run_ctl(1'b0);
    check("acc_first_gcd", 32'(gcd_out), 2);
    offer(8'd9, 8'd6);
    run_ctl(1'b1);
    check("acc_gcd_replaced", 32'(gcd_out), 3);
    check("acc_out_valid", 32'(out_valid), 1);
    check("acc_no_overrun", 32'(err_overrun), 0);
    drain();

    // restart during SUB of GCD(200,3) with new pair (10,10)
    offer(8'd200, 8'd3);
    n_rst = 1'b1;                       // cycle 0
    step();
    n_rst = 1'b0;                       // cycle 1: CMP, hold refills
    in_valid = 1'b1;
    a_in = 8'd10;
    b_in = 8'd10;
    check("rs_c1_a_gt_b", 32'(a_gt_b), 1);
    step();                             // cycle 2: SUB
    in_valid = 1'b0;
    a_sub_b = 1'b1;
    check("rs_hold_full", 32'(in_ready), 0);
    step();                             // cycle 3: CMP
    check("rs_c3_reg_a", 32'(dut.reg_a), 197);
    step();                             // cycle 4: SUB, reload wins
    n_rst = 1'b1;
    step();                             // cycle 5: CMP
    n_rst = 1'b0;
    a_sub_b = 1'b0;
    check("rs_equal", 32'(equal), 1);
    check("rs_reg_a", 32'(dut.reg_a), 10);
    found = 1'b1;
    step();
    found = 1'b0;
    check("rs_gcd", 32'(gcd_out), 10);
    check("rs_out_valid", 32'(out_valid), 1);

    // asynchronous reset mid-operation with a pending result and full hold
    offer(8'd12, 8'd8);
    n_rst = 1'b1;
    step();
    n_rst = 1'b0;
    offer(8'd5, 8'd3);
    check("mid_a_gt_b", 32'(a_gt_b), 1);
    check("mid_hold_full", 32'(in_ready), 0);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("rst2");
    #2 rst = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
